// File: rtl/toi2s_pkg.sv
// Shared definitions for the toi2s output path.
// Holds the default channel width and bit-clock divider, the serializer
// FSM state type and the frame-length helper.
package toi2s_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int BCLK_DIV_DEF  = 4;
    localparam int FRAME_LEN_DEF = 2 * WIDTH_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

    function automatic int frame_len(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider for the I2S transmitter.
// Counts clk cycles 0..BCLK_DIV-1 while run is high and produces a
// registered bclk plus single-cycle rise/fall ticks. The counter and bclk
// are held at zero while run is low.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   run       in   divider enable; low clears the counter and bclk
//   bclk      out  registered bit clock
//   rise_tick out  high in the cycle whose closing edge raises bclk
//   fall_tick out  high in the cycle whose closing edge lowers bclk
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] RISE_AT = DW'(BCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] FALL_AT = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign rise_tick = run && (div_cnt == RISE_AT);
    assign fall_tick = run && (div_cnt == FALL_AT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (fall_tick) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (rise_tick) begin
                bclk <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer and bus clock master.
// Accepts stereo PCM pairs over valid/ready into a one-deep holding
// register and shifts them out MSB first as BCLK/LRCLK/SDATA. A frame is
// 2*WIDTH bit clocks; the frame in progress always completes when ena drops.
//
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing
// (lrclk high during the left word, no one-bit delay). Default is Philips I2S.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   run enable
//   s_valid  in   sample pair valid
//   s_ready  out  holding register empty (registered)
//   s_left   in   left sample, two's complement
//   s_right  in   right sample, two's complement
//   bclk     out  bit clock
//   lrclk    out  word select, 0 = left (I2S mode)
//   sdata    out  serial data, MSB first
//   underrun out  one-clk pulse when a frame starts with the hold empty
//
// State | meaning
// IDLE  | bus outputs held low, counters parked, hold may still be filled
// RUN   | divider running, one frame shifted per 2*WIDTH bit clocks
module i2s_tx_serializer
    import toi2s_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int BW    = $clog2(FRAME);
    localparam logic [BW-1:0] LAST     = BW'(FRAME - 1);
    localparam logic [BW-1:0] LEFT_END = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LR_END   = BW'(FRAME - 2);

    i2s_state_t state, state_nxt;

    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [FRAME-1:0] shreg, load_data;
    logic [WIDTH-1:0] hold_l, hold_r;
    logic             hold_full, hold_full_nxt;
    logic             run, fall_tick, frame_end, frame_load, xfer, lr_nxt;
    // The serializer only acts on falling bit-clock edges.
    logic             rise_tick_unused;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .bclk      (bclk),
        .rise_tick (rise_tick_unused),
        .fall_tick (fall_tick)
    );

    assign run        = (state == RUN);
    assign frame_end  = fall_tick && (bit_cnt == LAST);
    assign frame_load = frame_end && ena;
    assign xfer       = s_valid && s_ready;
    assign bit_nxt    = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    // The load sees the hold as it was before this edge, so a sample
    // arriving on the load edge waits for the next frame.
    assign load_data  = hold_full ? {hold_l, hold_r} : '0;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    assign lr_nxt = (bit_nxt <= LEFT_END);
`else
    // Word select leads the data by one bit clock.
    assign lr_nxt = (bit_nxt >= LEFT_END) && (bit_nxt <= LR_END);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ena) state_nxt = RUN;
            RUN:     if (frame_end && !ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hold_full_nxt = hold_full;
        if (xfer) begin
            hold_full_nxt = 1'b1;
        end else if (frame_load) begin
            hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            s_ready   <= 1'b1;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            hold_full <= hold_full_nxt;
            s_ready   <= !hold_full_nxt;
            if (xfer) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= LAST;
            shreg    <= '0;
            sdata    <= 1'b0;
            lrclk    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!run || (frame_end && !ena)) begin
                bit_cnt <= LAST;
                shreg   <= '0;
                sdata   <= 1'b0;
                lrclk   <= 1'b0;
            end else if (fall_tick) begin
                bit_cnt <= bit_nxt;
                lrclk   <= lr_nxt;
                if (frame_load) begin
                    sdata    <= load_data[FRAME-1];
                    shreg    <= {load_data[FRAME-2:0], 1'b0};
                    underrun <= !hold_full;
                end else begin
                    sdata <= shreg[FRAME-1];
                    shreg <= {shreg[FRAME-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed testbench for i2s_tx_serializer (WIDTH=16, BCLK_DIV=4).
// Honours I2S_TX_LEFT_JUSTIFIED_EN for the expected word-select pattern.
module tb_i2s_tx_serializer;

    localparam int W   = 16;
    localparam int DIV = 4;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic [31:0] EXP_LR = 32'hFFFF_0000;
`else
    localparam logic [31:0] EXP_LR = 32'h0001_FFFE;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          ena     = 1'b0;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_left  = '0;
    logic [W-1:0]  s_right = '0;
    logic          s_ready, bclk, lrclk, sdata, underrun;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic bclk_q      = 1'b0;
    logic ur_q        = 1'b0;
    int   ur_pulses   = 0;
    int   ur_hi       = 0;
    int   ur_last_t   = 0;
    int   ur_prev_t   = 0;
    int   last_rise_t = 0;
    bit   have_prev   = 0;

    i2s_tx_serializer #(.WIDTH(W), .BCLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        bclk_q <= bclk;
        ur_q   <= underrun;
        if (underrun) begin
            ur_hi <= ur_hi + 1;
            if (!ur_q) begin
                ur_pulses <= ur_pulses + 1;
                ur_prev_t <= ur_last_t;
                ur_last_t <= cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Waits for the next bclk rising edge (seen at a falling clk edge).
    task automatic get_bit(output logic d, output logic lr, output int gap, output bit ok);
        ok  = 0;
        gap = 0;
        d   = 1'b0;
        lr  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bclk && !bclk_q) begin
                d   = sdata;
                lr  = lrclk;
                gap = have_prev ? (cyc - last_rise_t) : DIV;
                last_rise_t = cyc;
                have_prev   = 1;
                ok          = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL bclk_timeout: got no rising edge, required one within 64 clk");
        end
    endtask

    // Captures 32 bits MSB first; drops ena after bit index drop_at.
    task automatic capture_frame(input int drop_at, output logic [31:0] d, output logic [31:0] lr,
                                 output int min_gap, output int max_gap, output bit ok);
        logic b, l;
        int   g;
        d = '0;
        lr = '0;
        min_gap = 1000;
        max_gap = 0;
        ok = 0;
        for (int k = 0; k < 32; k++) begin
            get_bit(b, l, g, ok);
            if (!ok) return;
            d  = {d[30:0], b};
            lr = {lr[30:0], l};
            if (g < min_gap) min_gap = g;
            if (g > max_gap) max_gap = g;
            if (k == drop_at) ena = 1'b0;
        end
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
        bit ok;
        ok      = 0;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        for (int t = 0; t < 2000; t++) begin
            if (s_ready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: s_ready stayed 0, required 1 within 2000 clk");
        end
    endtask

    task automatic do_reset();
        ena     = 1'b0;
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        have_prev = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int p0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bclk, lrclk, sdata, underrun, s_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_values: got %b, required 00001 (bclk lrclk sdata underrun s_ready)",
                     {bclk, lrclk, sdata, underrun, s_ready});
        end
        rst_n = 1'b1;
        p0 = ur_pulses;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            vectors++;
            if ({bclk, lrclk, sdata, s_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL idle_outputs: cycle %0d got %b, required 0001", i, {bclk, lrclk, sdata, s_ready});
            end
        end
        @(negedge clk);
        vectors++;
        if (ur_pulses !== p0) begin
            miscompares++;
            $display("FAIL idle_underrun: got %0d pulses, required 0", ur_pulses - p0);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d, lr;
        logic b, l;
        int g, gmin, gmax;
        bit ok;
        do_reset();
        push(16'hA5C3, 16'h0F01);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_xfer: got %b, required 0", s_ready);
        end
        ena = 1'b1;
        get_bit(b, l, g, ok);
        vectors++;
        if ({b, l} !== 2'b00) begin
            miscompares++;
            $display("FAIL lead_in_bit: got sdata/lrclk %b, required 00", {b, l});
        end
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_load: got %b, required 0", s_ready);
        end
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_load: got %b, required 1", s_ready);
        end
        capture_frame(31, d, lr, gmin, gmax, ok);
        vectors++;
        if (d !== 32'hA5C3_0F01) begin
            miscompares++;
            $display("FAIL single_data: got %h, required a5c30f01", d);
        end
        vectors++;
        if (lr !== EXP_LR) begin
            miscompares++;
            $display("FAIL single_lrclk: got %h, required %h", lr, EXP_LR);
        end
        vectors++;
        if (gmin !== DIV || gmax !== DIV) begin
            miscompares++;
            $display("FAIL bclk_period: got min %0d max %0d, required %0d", gmin, gmax, DIV);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        push(16'h1234, ~16'h1234);
        ena = 1'b1;
        p0 = ur_pulses;
        fork
            begin
                for (int i = 1; i < 8; i++) begin
                    push(16'h1234 + 16'(i) * 16'h1111, ~(16'h1234 + 16'(i) * 16'h1111));
                end
            end
            begin
                logic [31:0] d, lr;
                logic [15:0] el;
                logic b, l;
                int g, gmin, gmax;
                bit ok;
                get_bit(b, l, g, ok);
                for (int f = 0; f < 8; f++) begin
                    el = 16'h1234 + 16'(f) * 16'h1111;
                    capture_frame((f == 7) ? 31 : -1, d, lr, gmin, gmax, ok);
                    vectors++;
                    if (d !== {el, ~el}) begin
                        miscompares++;
                        $display("FAIL b2b_data: frame %0d got %h, required %h", f, d, {el, ~el});
                    end
                    vectors++;
                    if (lr !== EXP_LR || gmin !== DIV || gmax !== DIV) begin
                        miscompares++;
                        $display("FAIL b2b_timing: frame %0d got lr %h gaps %0d/%0d, required %h gaps %0d",
                                 f, lr, gmin, gmax, EXP_LR, DIV);
                    end
                end
            end
        join
        repeat (8) @(negedge clk);
        vectors++;
        if (ur_pulses !== p0) begin
            miscompares++;
            $display("FAIL b2b_underrun: got %0d pulses, required 0", ur_pulses - p0);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] d, lr;
        logic b, l;
        int g, gmin, gmax, p0, h0;
        bit ok;
        do_reset();
        ena = 1'b1;
        p0 = ur_pulses;
        h0 = ur_hi;
        get_bit(b, l, g, ok);
        capture_frame(-1, d, lr, gmin, gmax, ok);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL underrun_zeros1: got %h, required 00000000", d);
        end
        fork
            capture_frame(-1, d, lr, gmin, gmax, ok);
            begin
                repeat (20) @(negedge clk);
                push(16'h8001, 16'h7FFE);
            end
        join
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL underrun_zeros2: got %h, required 00000000", d);
        end
        capture_frame(31, d, lr, gmin, gmax, ok);
        vectors++;
        if (d !== 32'h8001_7FFE) begin
            miscompares++;
            $display("FAIL late_sample: got %h, required 80017ffe", d);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (ur_pulses - p0 !== 2 || ur_hi - h0 !== 2) begin
            miscompares++;
            $display("FAIL underrun_pulses: got %0d pulses %0d high cycles, required 2 and 2",
                     ur_pulses - p0, ur_hi - h0);
        end
        vectors++;
        if (ur_last_t - ur_prev_t !== 128) begin
            miscompares++;
            $display("FAIL underrun_spacing: got %0d clk, required 128", ur_last_t - ur_prev_t);
        end
    endtask

    task automatic test_ena_midframe();
        logic [31:0] d, lr;
        logic b, l;
        int g, gmin, gmax, p0;
        bit ok;
        do_reset();
        push(16'hC3A5, 16'h5AF0);
        ena = 1'b1;
        p0 = ur_pulses;
        get_bit(b, l, g, ok);
        capture_frame(10, d, lr, gmin, gmax, ok);
        vectors++;
        if (d !== 32'hC3A5_5AF0 || lr !== EXP_LR) begin
            miscompares++;
            $display("FAIL midframe_complete: got %h lr %h, required c3a55af0 lr %h", d, lr, EXP_LR);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({bclk, lrclk, sdata} !== 3'b000) begin
                miscompares++;
                $display("FAIL midframe_idle: cycle %0d got %b, required 000", i, {bclk, lrclk, sdata});
            end
        end
        vectors++;
        if (ur_pulses !== p0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_status: got %0d pulses ready %b, required 0 and 1", ur_pulses - p0, s_ready);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, lr;
        logic b, l;
        int g, gmin, gmax, p0;
        bit ok;
        do_reset();
        push(16'hFFFF, 16'hFFFF);
        ena = 1'b1;
        get_bit(b, l, g, ok);
        for (int k = 0; k < 5; k++) begin
            get_bit(b, l, g, ok);
            vectors++;
            if (b !== 1'b1) begin
                miscompares++;
                $display("FAIL ones_bit: bit %0d got %b, required 1", k, b);
            end
        end
        push(16'h1111, 16'h2222);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_full_before_rst: got ready %b, required 0", s_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bclk) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bclk, lrclk, sdata, underrun, s_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL async_reset: got %b, required 00001", {bclk, lrclk, sdata, underrun, s_ready});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        have_prev = 0;
        p0        = ur_pulses;
        get_bit(b, l, g, ok);
        capture_frame(31, d, lr, gmin, gmax, ok);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL hold_lost: got %h, required 00000000", d);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (ur_pulses - p0 !== 1) begin
            miscompares++;
            $display("FAIL post_reset_underrun: got %0d pulses, required 1", ur_pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_ena_midframe();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
